// File: rtl/yd_wb_sched_if.sv
// Writeback-scheduler bus: producer requests in, register-file write ports and pending scoreboard out.
interface yd_wb_sched_if #(
    parameter int DW = 16,
    parameter int AW = 4
);
    logic            flush;
    logic [2:0]      req_valid;
    logic [2:0]      req_ready;
    logic [3*AW-1:0] req_addr;
    logic [3*DW-1:0] req_data;
    logic            we0;
    logic [AW-1:0]   waddr0;
    logic [DW-1:0]   din0;
    logic            we1;
    logic [AW-1:0]   waddr1;
    logic [DW-1:0]   din1;
    logic            jpc;
    logic [15:0]     pend;

    // Handshake: producer i transfers on a rising edge where req_valid[i] && req_ready[i].
    // req_ready depends on registered occupancy only; a transfer during flush is accepted and discarded.
    modport master (
        output flush, req_valid, req_addr, req_data,
        input  req_ready, we0, waddr0, din0, we1, waddr1, din1, jpc, pend
    );

    modport slave (
        input  flush, req_valid, req_addr, req_data,
        output req_ready, we0, waddr0, din0, we1, waddr1, din1, jpc, pend
    );
endinterface

// File: rtl/yd_wb_sched.sv
// Writeback scheduler: three producer FIFOs arbitrated round-robin onto two register-file write ports.
module yd_wb_sched #(
    parameter int DEPTH = 2,
    parameter int DW    = 16,
    parameter int AW    = 4
) (
    input  logic         clk,
    input  logic         rst,
    yd_wb_sched_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [AW-1:0] PC_ADDR = AW'(15);

    logic [AW-1:0] fa_q [3][DEPTH];
    logic [DW-1:0] fd_q [3][DEPTH];
    logic [PW-1:0] wp_q [3];
    logic [PW-1:0] rp_q [3];
    logic [PW-1:0] wp_d [3];
    logic [PW-1:0] rp_d [3];
    logic [1:0]    rr_q, rr_d;

    logic          we0_q, we1_q, jpc_q;
    logic [AW-1:0] waddr0_q, waddr1_q;
    logic [DW-1:0] din0_q, din1_q;

    logic [2:0]    full, empty, push, pop, drop, elig, grant;
    logic [AW-1:0] head_a [3];
    logic [DW-1:0] head_d [3];

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            empty[i]  = (wp_q[i] == rp_q[i]);
            full[i]   = (wp_q[i][IW] != rp_q[i][IW]) && (wp_q[i][IW-1:0] == rp_q[i][IW-1:0]);
            head_a[i] = fa_q[i][rp_q[i][IW-1:0]];
            head_d[i] = fd_q[i][rp_q[i][IW-1:0]];
            drop[i]   = !empty[i] && (head_a[i] == '0);
            elig[i]   = !empty[i] && (head_a[i] != '0) && !bus.flush;
            push[i]   = bus.req_valid[i] && !full[i] && !bus.flush;
        end
    end

    // Slot A is the first eligible head in rotated order; slot B the next one with a different address.
    logic       a_vld, b_vld;
    logic [1:0] a_idx, b_idx, scan_idx;
    logic [2:0] scan_sum;

    always_comb begin
        a_vld    = 1'b0;
        b_vld    = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        scan_idx = '0;
        scan_sum = '0;
        for (int k = 0; k < 3; k++) begin
            scan_sum = {1'b0, rr_q} + 3'(k);
            scan_idx = (scan_sum >= 3'd3) ? 2'(scan_sum - 3'd3) : scan_sum[1:0];
            if (elig[scan_idx]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = scan_idx;
                end else if (!b_vld && (head_a[scan_idx] != head_a[a_idx])) begin
                    b_vld = 1'b1;
                    b_idx = scan_idx;
                end
            end
        end
    end

    logic          swap;
    logic [AW-1:0] p0_a, p1_a;
    logic [DW-1:0] p0_d, p1_d;

    assign grant = (a_vld ? (3'b001 << a_idx) : 3'b000) | (b_vld ? (3'b001 << b_idx) : 3'b000);
    assign pop   = grant | drop;
    assign swap  = b_vld && (head_a[b_idx] == PC_ADDR);
    assign p0_a  = swap ? head_a[b_idx] : head_a[a_idx];
    assign p0_d  = swap ? head_d[b_idx] : head_d[a_idx];
    assign p1_a  = swap ? head_a[a_idx] : head_a[b_idx];
    assign p1_d  = swap ? head_d[a_idx] : head_d[b_idx];
    assign rr_d  = !a_vld ? rr_q : (b_vld ? rr_next(b_idx) : rr_next(a_idx));

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            wp_d[i] = bus.flush ? '0 : wp_q[i] + PW'(push[i]);
            rp_d[i] = bus.flush ? '0 : rp_q[i] + PW'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                wp_q[i] <= '0;
                rp_q[i] <= '0;
            end
            rr_q     <= '0;
            we0_q    <= 1'b0;
            we1_q    <= 1'b0;
            jpc_q    <= 1'b0;
            waddr0_q <= '0;
            waddr1_q <= '0;
            din0_q   <= '0;
            din1_q   <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                wp_q[i] <= wp_d[i];
                rp_q[i] <= rp_d[i];
            end
            rr_q     <= rr_d;
            we0_q    <= a_vld;
            we1_q    <= b_vld;
            jpc_q    <= a_vld && (p0_a == PC_ADDR);
            waddr0_q <= p0_a;
            waddr1_q <= p1_a;
            din0_q   <= p0_d;
            din1_q   <= p1_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                fa_q[i][wp_q[i][IW-1:0]] <= bus.req_addr[i*AW +: AW];
                fd_q[i][wp_q[i][IW-1:0]] <= bus.req_data[i*DW +: DW];
            end
        end
    end

    // Live entries are those whose offset from the read pointer is below the occupancy count.
    logic [15:0]   pend_c;
    logic [PW-1:0] cnt;
    logic [IW-1:0] off;

    always_comb begin
        pend_c = '0;
        cnt    = '0;
        off    = '0;
        for (int i = 0; i < 3; i++) begin
            cnt = wp_q[i] - rp_q[i];
            for (int j = 0; j < DEPTH; j++) begin
                off = IW'(j) - rp_q[i][IW-1:0];
                if ({1'b0, off} < cnt) pend_c = pend_c | (16'd1 << fa_q[i][j]);
            end
        end
        if (we0_q) pend_c = pend_c | (16'd1 << waddr0_q);
        if (we1_q) pend_c = pend_c | (16'd1 << waddr1_q);
        pend_c[0] = 1'b0;
    end

    assign bus.req_ready = ~full;
    assign bus.we0       = we0_q;
    assign bus.waddr0    = waddr0_q;
    assign bus.din0      = din0_q;
    assign bus.we1       = we1_q;
    assign bus.waddr1    = waddr1_q;
    assign bus.din1      = din1_q;
    assign bus.jpc       = jpc_q;
    assign bus.pend      = pend_c;
endmodule

// File: tb/tb_yd_wb_sched.sv
// Directed and randomized bench for yd_wb_sched, compared each cycle against a queue-based model.
module tb_yd_wb_sched;
    localparam int DEPTH = 2;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int EW    = AW + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    yd_wb_sched_if #(.DW(DW), .AW(AW)) bus ();

    yd_wb_sched #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: per-producer queues of {addr, data}, rotating priority, one output stage.
    logic [EW-1:0] exp_q [3][$];
    logic [EW-1:0] src_q [3][$];
    int            m_rr;
    logic          e_we0, e_we1;
    logic [AW-1:0] e_a0, e_a1;
    logic [DW-1:0] e_d0, e_d1;
    logic          count_en = 1'b0;
    int            prod_cnt [3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    endtask

    function automatic logic [EW-1:0] mk(input int a, input int d);
        return {AW'(a), DW'(d)};
    endfunction

    task automatic model_step();
        logic [2:0]    rdy;
        bit            dropped [3];
        int            nw;
        int            p;
        int            w_p [2];
        logic [EW-1:0] w_e [2];
        logic [EW-1:0] t;
        nw     = 0;
        w_e[0] = '0;
        w_e[1] = '0;
        w_p[0] = 0;
        w_p[1] = 0;
        if (rst) begin
            for (int i = 0; i < 3; i++) exp_q[i].delete();
            m_rr  = 0;
            e_we0 = 1'b0; e_we1 = 1'b0;
            e_a0  = '0;   e_a1  = '0;
            e_d0  = '0;   e_d1  = '0;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            rdy[i]     = (exp_q[i].size() < DEPTH);
            dropped[i] = 1'b0;
            if (exp_q[i].size() > 0) begin
                t = exp_q[i][0];
                if (t[EW-1:DW] == '0) begin
                    void'(exp_q[i].pop_front());
                    dropped[i] = 1'b1;
                end
            end
        end
        if (!bus.flush) begin
            for (int k = 0; k < 3; k++) begin
                p = (m_rr + k) % 3;
                if (!dropped[p] && exp_q[p].size() > 0 && nw < 2) begin
                    t = exp_q[p][0];
                    if (nw == 0 || t[EW-1:DW] != w_e[0][EW-1:DW]) begin
                        w_e[nw] = t;
                        w_p[nw] = p;
                        nw++;
                    end
                end
            end
        end
        for (int n = 0; n < nw; n++) void'(exp_q[w_p[n]].pop_front());
        if (bus.flush) begin
            for (int i = 0; i < 3; i++) exp_q[i].delete();
        end else begin
            for (int i = 0; i < 3; i++)
                if (bus.req_valid[i] && rdy[i])
                    exp_q[i].push_back({bus.req_addr[i*AW +: AW], bus.req_data[i*DW +: DW]});
        end
        e_we0 = (nw > 0);
        e_we1 = (nw > 1);
        if (nw == 2 && w_e[1][EW-1:DW] == AW'(15)) begin
            {e_a0, e_d0} = w_e[1];
            {e_a1, e_d1} = w_e[0];
        end else begin
            {e_a0, e_d0} = w_e[0];
            {e_a1, e_d1} = w_e[1];
        end
        if (nw > 0) m_rr = (w_p[nw-1] + 1) % 3;
    endtask

    task automatic count_owner(input logic [AW-1:0] a);
        if (a >= AW'(2) && a <= AW'(13)) prod_cnt[(int'(a) - 2) / 4]++;
    endtask

    task automatic compare_outputs();
        logic [15:0]   pm;
        logic [2:0]    rdy;
        logic [EW-1:0] t;
        pm = '0;
        for (int i = 0; i < 3; i++) begin
            rdy[i] = (exp_q[i].size() < DEPTH);
            for (int j = 0; j < exp_q[i].size(); j++) begin
                t = exp_q[i][j];
                pm[t[EW-1:DW]] = 1'b1;
            end
        end
        if (e_we0) pm[e_a0] = 1'b1;
        if (e_we1) pm[e_a1] = 1'b1;
        pm[0] = 1'b0;
        check_eq("req_ready", bus.req_ready, rdy);
        check_eq("we0", bus.we0, e_we0);
        check_eq("we1", bus.we1, e_we1);
        check_eq("jpc", bus.jpc, e_we0 && (e_a0 == AW'(15)));
        if (e_we0) begin
            check_eq("waddr0", bus.waddr0, e_a0);
            check_eq("din0", bus.din0, e_d0);
        end
        if (e_we1) begin
            check_eq("waddr1", bus.waddr1, e_a1);
            check_eq("din1", bus.din1, e_d1);
        end
        check_eq("pend", bus.pend, pm);
        if (count_en) begin
            if (bus.we0) count_owner(bus.waddr0);
            if (bus.we1) count_owner(bus.waddr1);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        compare_outputs();
    endtask

    task automatic drive_tick(input logic [2:0] en, input logic fl);
        logic [2:0]      v, rdy_pre;
        logic [3*AW-1:0] av;
        logic [3*DW-1:0] dv;
        logic [EW-1:0]   t;
        av = '0;
        dv = '0;
        for (int i = 0; i < 3; i++) begin
            v[i] = en[i] && (src_q[i].size() > 0);
            if (v[i]) t = src_q[i][0];
            else t = EW'($urandom);
            av[i*AW +: AW] = t[EW-1:DW];
            dv[i*DW +: DW] = t[DW-1:0];
        end
        bus.req_valid = v;
        bus.req_addr  = av;
        bus.req_data  = dv;
        bus.flush     = fl;
        rdy_pre       = bus.req_ready;
        tick();
        for (int i = 0; i < 3; i++)
            if (v[i] && rdy_pre[i]) void'(src_q[i].pop_front());
        bus.req_valid = '0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.flush     = 1'b0;
        for (int i = 0; i < 3; i++) src_q[i].delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // Single ALU write: visible two cycles after the push.
        do_reset();
        check_eq("rst_ready", bus.req_ready, 3'b111);
        check_eq("rst_pend", bus.pend, 16'h0000);
        check_eq("rst_we0", bus.we0, 1'b0);
        src_q[0].push_back(mk(2, 'h1234));
        drive_tick(3'b111, 1'b0);
        check_eq("t1_pend2_c1", bus.pend[2], 1'b1);
        drive_tick(3'b111, 1'b0);
        check_eq("t1_we0", bus.we0, 1'b1);
        check_eq("t1_waddr0", bus.waddr0, 4'd2);
        check_eq("t1_din0", bus.din0, 16'h1234);
        check_eq("t1_we1", bus.we1, 1'b0);
        check_eq("t1_pend2_c2", bus.pend[2], 1'b1);
        drive_tick(3'b111, 1'b0);
        check_eq("t1_pend2_c3", bus.pend[2], 1'b0);

        // Same-address conflict: ALU first, LSU a cycle later.
        do_reset();
        src_q[0].push_back(mk(3, 'hAAAA));
        src_q[1].push_back(mk(3, 'hBBBB));
        drive_tick(3'b111, 1'b0);
        drive_tick(3'b111, 1'b0);
        check_eq("t2_we0_a", bus.we0, 1'b1);
        check_eq("t2_din0_a", bus.din0, 16'hAAAA);
        check_eq("t2_we1_a", bus.we1, 1'b0);
        drive_tick(3'b111, 1'b0);
        check_eq("t2_waddr0_b", bus.waddr0, 4'd3);
        check_eq("t2_din0_b", bus.din0, 16'hBBBB);
        check_eq("t2_we1_b", bus.we1, 1'b0);

        // PC write steered to port 0; a second PC write waits.
        do_reset();
        src_q[1].push_back(mk(15, 'h0040));
        src_q[0].push_back(mk(4, 'h0001));
        src_q[2].push_back(mk(15, 'h0077));
        drive_tick(3'b111, 1'b0);
        drive_tick(3'b111, 1'b0);
        check_eq("t3_waddr0", bus.waddr0, 4'd15);
        check_eq("t3_din0", bus.din0, 16'h0040);
        check_eq("t3_jpc", bus.jpc, 1'b1);
        check_eq("t3_we1", bus.we1, 1'b1);
        check_eq("t3_waddr1", bus.waddr1, 4'd4);
        drive_tick(3'b111, 1'b0);
        check_eq("t3_io_din0", bus.din0, 16'h0077);
        check_eq("t3_io_jpc", bus.jpc, 1'b1);
        check_eq("t3_io_we1", bus.we1, 1'b0);

        // Zero-register drop, then the following write.
        do_reset();
        src_q[0].push_back(mk(0, 'hFFFF));
        src_q[0].push_back(mk(5, 'h0005));
        drive_tick(3'b111, 1'b0);
        check_eq("t4_pend0_c1", bus.pend[0], 1'b0);
        drive_tick(3'b111, 1'b0);
        check_eq("t4_we0_c2", bus.we0, 1'b0);
        drive_tick(3'b111, 1'b0);
        check_eq("t4_waddr0", bus.waddr0, 4'd5);
        check_eq("t4_din0", bus.din0, 16'h0005);

        // Three producers held valid for 12 cycles: two writes per cycle, 8 grants each.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            prod_cnt[p] = 0;
            for (int n = 0; n < 12; n++) src_q[p].push_back(mk(2 + 4*p + (n % 4), int'($urandom)));
        end
        for (int t = 0; t <= 12; t++) begin
            count_en = (t >= 1);
            drive_tick((t < 12) ? 3'b111 : 3'b000, 1'b0);
        end
        count_en = 1'b0;
        for (int p = 0; p < 3; p++) check_eq($sformatf("t5_grants%0d", p), prod_cnt[p], 8);
        for (int i = 0; i < 3; i++) src_q[i].delete();
        for (int t = 0; t < 6; t++) drive_tick(3'b000, 1'b0);

        // Flush with an entry buffered: the issued write survives, nothing else follows.
        do_reset();
        src_q[0].push_back(mk(6, 'h0606));
        src_q[0].push_back(mk(7, 'h0707));
        src_q[0].push_back(mk(8, 'h0808));
        drive_tick(3'b001, 1'b0);
        drive_tick(3'b001, 1'b0);
        check_eq("t6_waddr0", bus.waddr0, 4'd6);
        check_eq("t6_pend7", bus.pend[7], 1'b1);
        drive_tick(3'b001, 1'b1);
        check_eq("t6_we0_after", bus.we0, 1'b0);
        check_eq("t6_pend_after", bus.pend, 16'h0000);
        check_eq("t6_ready_after", bus.req_ready, 3'b111);
        drive_tick(3'b000, 1'b0);
        check_eq("t6_we0_late", bus.we0, 1'b0);

        // Randomized traffic with occasional flushes.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [2:0] en;
            for (int i = 0; i < 3; i++) begin
                if (src_q[i].size() == 0)
                    src_q[i].push_back(mk($urandom_range(0, 15), int'($urandom)));
                en[i] = ($urandom_range(0, 99) < 60);
            end
            drive_tick(en, ($urandom_range(0, 29) == 0));
        end
        for (int i = 0; i < 3; i++) src_q[i].delete();
        for (int t = 0; t < 8; t++) drive_tick(3'b000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/yd_wb_sched.md
Name: yd_wb_sched

Overview:
- Writeback scheduler for the Yduck 16-bit core's dual-write-port register file.
- Accepts writeback requests from three producers: 0 = ALU, 1 = LSU, 2 = IO/aux.
- Buffers each producer in a small FIFO and issues at most two writes per cycle onto the register file's we0/we1 ports.
- Issue rules: never two writes to the same address in one cycle; PC writes only on port 0 with jpc asserted. It also exports a pending-write scoreboard for decode hazard checks.

Parameters:
- DEPTH, 2, entries per producer FIFO; power of two, 2 or 4.
- DW, 16, data width.
- AW, 4, register address width. Address 0 = zero register, 1 = DK, 15 = PC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash all buffered, not-yet-issued requests
- req_valid  in  3  per-producer request valid
- req_ready  out  3  per-producer FIFO not full
- req_addr  in  3*AW  per-producer destination address; producer i uses bits [i*AW +: AW]
- req_data  in  3*DW  per-producer write data; producer i uses bits [i*DW +: DW]
- we0  out  1  register-file write enable, port 0
- waddr0  out  AW  port 0 address
- din0  out  DW  port 0 data
- we1  out  1  register-file write enable, port 1
- waddr1  out  AW  port 1 address
- din1  out  DW  port 1 data
- jpc  out  1  PC write strobe to the register file; high only with a PC write on port 0
- pend  out  16  bit r set = a write to register r is buffered or in the output stage

Behaviour:
- Reset: rst clears all FIFOs, the round-robin pointer (rr=0) and output regs.
  - we0, we1, jpc = 0; waddr0/1 = 0; din0/1 = 0; pend = 0.
  - req_ready = 3'b111 from the first cycle after reset.
  - rst has priority over flush and over any push.
- Push: producer i pushes when req_valid[i] && req_ready[i].
  - req_ready[i] = !full_i, registered state only. It does not depend on a same-cycle pop.
  - A full FIFO refuses the push even if it pops in that cycle.
- Zero-register drop: a FIFO head with addr 0 is popped in the cycle it is at the head.
  - It takes no issue slot and never produces a write enable.
- Issue selection: combinational over the valid non-zero heads.
  - Scan order is rr, rr+1, rr+2 (mod 3).
  - The first eligible head takes slot A.
  - The next eligible head takes slot B if its addr differs from slot A's and it is not a second PC write.
  - Otherwise that head waits. The scan continues to the third head under the same rules.
  - At most two pops per cycle, plus zero-register drops.
- Port mapping: if either granted write targets addr 15, it goes on port 0 and the other on port 1. Otherwise slot A goes on port 0 and slot B on port 1.
- Output stage: registered, so latency from pop to we asserted is exactly 1 cycle.
  - Minimum push-to-write is 2 cycles: push at cycle N, head/issue at N+1, we high at N+2.
  - jpc = 1 in exactly the cycles where we0 = 1 and waddr0 = 15.
  - Unused ports hold we = 0; their address/data values are don't-care.
- Round-robin update: when at least one write is granted, rr becomes (index of last granted producer + 1) mod 3. Otherwise rr holds.
- Ordering: FIFO order is preserved per producer. Order across producers is by arbitration only.
  - Same-address writes from different producers are never issued in the same cycle.
- pend: OR over all valid FIFO entries (one-hot of addr) and the output-stage ports with we = 1.
  - Bit 0 is always 0.
  - Computed combinationally from registered state only.
- Flush: all FIFO entries are invalidated at the clock edge. Pushes presented in the flush cycle are discarded.
  - The output stage is not squashed; writes already issued complete the next cycle.
  - In the cycle after flush, pend reflects only the output stage.
- Pointer wrap: FIFO read/write pointers are log2(DEPTH)+1 bits. Full/empty come from MSB comparison and are correct across wrap.

Test Plan:
- Reset, then push ALU {addr 2, data 16'h1234} at cycle 0.
  - Expect we0 = 1, waddr0 = 2, din0 = 16'h1234 at cycle 2; we1 = 0.
  - pend[2] = 1 for cycles 1-2 and 0 at cycle 3.
- ALU {addr 3, 16'hAAAA} and LSU {addr 3, 16'hBBBB} pushed in the same cycle, rr = 0.
  - Expect ALU's write issued alone (we0 = 1, waddr0 = 3, din0 = 16'hAAAA).
  - LSU's write follows one cycle later; both are never issued in one cycle.
- LSU {addr 15, 16'h0040} and ALU {addr 4, 16'h0001} pushed together.
  - Expect in one cycle: we0 = 1, waddr0 = 15, jpc = 1, we1 = 1, waddr1 = 4.
  - A further IO write to addr 15 waits a cycle.
- Push ALU {addr 0, 16'hFFFF}, then {addr 5, 16'h0005}.
  - Expect no write enable for addr 0, and pend[0] = 0 throughout.
  - The addr 5 write issues 1 cycle after the drop.
- Hold all three producers valid for 12 cycles with distinct addresses and DEPTH = 2.
  - Expect two writes per cycle and round-robin fairness: each producer is granted 8 times.
  - req_ready deasserts when a FIFO is full and the refused data is not lost.
- Fill the ALU FIFO (2 entries), issue one, then assert flush.
  - Expect the issued write still appears.
  - No further writes occur; pend = 0 after the output stage drains; req_ready = 3'b111.
